// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// default hold/gap lengths and the bit positions inside the cause register.
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_BUSREL = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int unsigned STRETCH_DEF = 16;
  localparam int unsigned GAP_DEF     = 4;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CAUSE_W = 4;

  localparam int unsigned CAUSE_SOFT = 0;
  localparam int unsigned CAUSE_WB   = 1;
  localparam int unsigned CAUSE_PIN  = 2;
  localparam int unsigned CAUSE_POR  = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_POR_ONLY = CAUSE_W'(1 << CAUSE_POR);

endpackage

// File: rtl/rst_sync2.sv
// Two-flop synchronizer for a level signal; both flops preset to 1 while
// the asynchronous reset is asserted.
module rst_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives a settled copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges soft, wishbone and pin reset requests, holds the bus
// reset for STRETCH cycles after the last request, then releases the core
// reset GAP cycles later. Keeps a sticky record of what caused the reset.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned STRETCH = STRETCH_DEF,
  parameter int unsigned GAP     = GAP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_soft_rst,
  input  logic               i_wb_rst,
  input  logic               i_pin_rst,
  input  logic               i_cause_clr,
  output logic               o_rst_bus,
  output logic               o_rst_core,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_busy
);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               pin_n_s;
  logic               pin_s;
  logic               req;
  logic [CAUSE_W-1:0] cause_set;

  // The pin is carried through the synchronizer inverted, so the preset-to-1
  // flops read as "no pin request" right after power-on reset is released.
  rst_sync2 u_pin_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (~i_pin_rst),
    .q     (pin_n_s)
  );

  assign pin_s = ~pin_n_s;
  assign req   = pin_s | i_soft_rst | i_wb_rst;

  // Next-state and counter logic; any request restarts the hold from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (req) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == STRETCH_LAST) begin
            state_nxt = ST_BUSREL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_BUSREL: begin
          if (cnt == GAP_LAST) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Cause bits raised this cycle by each synchronized request source.
  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_PIN]  = pin_s;
    cause_set[CAUSE_WB]   = i_wb_rst;
    cause_set[CAUSE_SOFT] = i_soft_rst;
  end

  // State register plus registered outputs decoded from the next state, so
  // the resets change on the same edge as the state with no decode glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      o_rst_bus  <= 1'b1;
      o_rst_core <= 1'b1;
      o_busy     <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_rst_bus  <= (state_nxt == ST_HOLD);
      o_rst_core <= (state_nxt != ST_RUN);
      o_busy     <= (state_nxt != ST_RUN);
    end
  end

  // Sticky cause register; a set on the same edge as a clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cause <= CAUSE_POR_ONLY;
    end else begin
      o_cause <= (i_cause_clr ? '0 : o_cause) | cause_set;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with default STRETCH=16, GAP=4.
module tb_rst_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_soft_rst = 1'b0;
  logic       i_wb_rst = 1'b0;
  logic       i_pin_rst = 1'b0;
  logic       i_cause_clr = 1'b0;
  logic       o_rst_bus;
  logic       o_rst_core;
  logic [3:0] o_cause;
  logic       o_busy;

  int tests = 0;
  int fails = 0;

  rst_seq_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_soft_rst  (i_soft_rst),
    .i_wb_rst    (i_wb_rst),
    .i_pin_rst   (i_pin_rst),
    .i_cause_clr (i_cause_clr),
    .o_rst_bus   (o_rst_bus),
    .o_rst_core  (o_rst_core),
    .o_cause     (o_cause),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_rst_bus, o_rst_core, o_busy} !== 3'b111) begin
      fails++;
      $display("FAIL reset_async_outs: got %b expected 111", {o_rst_bus, o_rst_core, o_busy});
    end
    tests++;
    if (o_cause !== 4'b1000) begin
      fails++;
      $display("FAIL reset_async_cause: got %b expected 1000", o_cause);
    end
    tick();
    tick();
    tick();
    tests++;
    if ({o_rst_bus, o_rst_core, o_busy, o_cause} !== 7'b1111000) begin
      fails++;
      $display("FAIL reset_held: got %b expected 1111000", {o_rst_bus, o_rst_core, o_busy, o_cause});
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_por();
    logic eb, ec;
    for (int e = 1; e <= 22; e++) begin
      tick();
      eb = (e < 16);
      ec = (e < 20);
      tests++;
      if ({o_rst_bus, o_rst_core, o_busy} !== {eb, ec, ec}) begin
        fails++;
        $display("FAIL por_seq edge %0d: got bus/core/busy %b expected %b", e, {o_rst_bus, o_rst_core, o_busy}, {eb, ec, ec});
      end
    end
    tests++;
    if (o_cause !== 4'b1000) begin
      fails++;
      $display("FAIL por_cause: got %b expected 1000", o_cause);
    end
  endtask

  task automatic test_wb_req();
    logic eb, ec;
    i_wb_rst = 1'b1;
    for (int j = 0; j <= 22; j++) begin
      tick();
      if (j == 0) i_wb_rst = 1'b0;
      eb = (j < 16);
      ec = (j < 20);
      tests++;
      if ({o_rst_bus, o_rst_core, o_busy} !== {eb, ec, ec}) begin
        fails++;
        $display("FAIL wb_seq k+%0d: got bus/core/busy %b expected %b", j, {o_rst_bus, o_rst_core, o_busy}, {eb, ec, ec});
      end
    end
    tests++;
    if (o_cause !== 4'b1010) begin
      fails++;
      $display("FAIL wb_cause: got %b expected 1010", o_cause);
    end
  endtask

  task automatic test_pin();
    logic eb, ec;
    i_pin_rst = 1'b1;
    for (int j = 0; j <= 25; j++) begin
      tick();
      if (j == 2) i_pin_rst = 1'b0;
      eb = (j >= 2) && (j < 20);
      ec = (j >= 2) && (j < 24);
      tests++;
      if ({o_rst_bus, o_rst_core} !== {eb, ec}) begin
        fails++;
        $display("FAIL pin_seq m+%0d: got bus/core %b expected %b", j, {o_rst_bus, o_rst_core}, {eb, ec});
      end
    end
    tests++;
    if (o_cause !== 4'b1110) begin
      fails++;
      $display("FAIL pin_cause: got %b expected 1110", o_cause);
    end
  endtask

  task automatic test_restart();
    logic eb, ec;
    i_wb_rst = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      tick();
      if (j == 0) i_wb_rst = 1'b0;
      if (j == 17) i_soft_rst = 1'b1;
      if (j == 18) i_soft_rst = 1'b0;
      eb = (j < 16) || ((j >= 18) && (j < 34));
      ec = (j < 38);
      tests++;
      if ({o_rst_bus, o_rst_core} !== {eb, ec}) begin
        fails++;
        $display("FAIL restart_seq k+%0d: got bus/core %b expected %b", j, {o_rst_bus, o_rst_core}, {eb, ec});
      end
    end
    tests++;
    if (o_cause !== 4'b1111) begin
      fails++;
      $display("FAIL restart_cause: got %b expected 1111", o_cause);
    end
  endtask

  task automatic test_held();
    logic eb, ec;
    i_soft_rst = 1'b1;
    for (int j = 0; j <= 121; j++) begin
      tick();
      if (j == 99) i_soft_rst = 1'b0;
      eb = (j < 115);
      ec = (j < 119);
      tests++;
      if ({o_rst_bus, o_rst_core} !== {eb, ec}) begin
        fails++;
        $display("FAIL held_seq +%0d: got bus/core %b expected %b", j, {o_rst_bus, o_rst_core}, {eb, ec});
      end
    end
  endtask

  task automatic test_cause();
    i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_rst_bus, o_rst_core, o_busy, o_cause} !== 7'b1111000) begin
      fails++;
      $display("FAIL cause_rerst: got %b expected 1111000", {o_rst_bus, o_rst_core, o_busy, o_cause});
    end
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    tests++;
    if (o_cause !== 4'b1001) begin
      fails++;
      $display("FAIL cause_soft: got %b expected 1001", o_cause);
    end
    i_cause_clr = 1'b1;
    i_wb_rst = 1'b1;
    tick();
    i_cause_clr = 1'b0;
    i_wb_rst = 1'b0;
    tests++;
    if (o_cause !== 4'b0010) begin
      fails++;
      $display("FAIL cause_clr_set: got %b expected 0010", o_cause);
    end
    i_cause_clr = 1'b1;
    tick();
    i_cause_clr = 1'b0;
    tests++;
    if (o_cause !== 4'b0000) begin
      fails++;
      $display("FAIL cause_clr: got %b expected 0000", o_cause);
    end
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_run timeout: busy %b expected 0", o_busy);
    end
  endtask

  task automatic test_multi();
    logic eb, ec;
    i_soft_rst = 1'b1;
    i_wb_rst = 1'b1;
    for (int j = 0; j <= 21; j++) begin
      tick();
      if (j == 0) begin
        i_soft_rst = 1'b0;
        i_wb_rst = 1'b0;
      end
      eb = (j < 16);
      ec = (j < 20);
      tests++;
      if ({o_rst_bus, o_rst_core, o_busy} !== {eb, ec, ec}) begin
        fails++;
        $display("FAIL multi_seq k+%0d: got bus/core/busy %b expected %b", j, {o_rst_bus, o_rst_core, o_busy}, {eb, ec, ec});
      end
    end
    tests++;
    if (o_cause !== 4'b0011) begin
      fails++;
      $display("FAIL multi_cause: got %b expected 0011", o_cause);
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_wb_req();
    test_pin();
    test_restart();
    test_held();
    test_cause();
    wait_run();
    test_multi();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
